// File: rtl/interval_arbiter.sv
// interval_arbiter: two requesters share one prescaled interval counter.
// A grant lasts (PS_MAX+1)*len cycles, then a one-cycle done pulse is issued.
// Optional feature: define ROUND_ROBIN_EN to alternate grants on ties between
// requesters; otherwise requester 0 always wins a tie.
module interval_arbiter #(
    parameter int unsigned CW     = 16,
    parameter int unsigned PS_MAX = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [CW-1:0] len0,
    input  logic          req1,
    input  logic [CW-1:0] len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          busy,
    output logic [2:0]    c0,
    output logic [CW-1:0] c1
);

    localparam logic [2:0]    PsTerm = 3'(PS_MAX);
    localparam logic [CW-1:0] CwOne  = CW'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] len_q, len_d;
    logic [2:0]    c0_q, c0_d;
    logic [CW-1:0] c1_q, c1_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          busy_q, busy_d;

    logic          win;
    logic [CW-1:0] win_len_raw;
    logic [CW-1:0] win_len;
    logic [CW-1:0] last_tick;
    logic          owner_req;

`ifdef ROUND_ROBIN_EN
    // Points at the requester favoured on a tie; flips only on completed intervals.
    logic prio_q, prio_d;

    // Winner selection: a lone request wins, a tie goes to the pointer.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = prio_q;
        end
    end
`else
    // Winner selection: fixed priority, requester 0 wins whenever it asks.
    always_comb begin
        win = ~req0;
    end
`endif

    assign win_len_raw = win ? len1 : len0;
    // A zero length would never terminate, so it runs as a single tick.
    assign win_len     = (win_len_raw == '0) ? CwOne : win_len_raw;
    assign last_tick   = len_q - CwOne;
    assign owner_req   = owner_q ? req1 : req0;

    // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        len_d   = len_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifdef ROUND_ROBIN_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            StIdle: begin
                c0_d = '0;
                c1_d = '0;
                if (req0 || req1) begin
                    state_d = StRun;
                    owner_d = win;
                    len_d   = win_len;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            StRun: begin
                if (!owner_req) begin
                    // Abort: the pointer is deliberately left untouched.
                    state_d = StIdle;
                    c0_d    = '0;
                    c1_d    = '0;
                end else if (c0_q == PsTerm) begin
                    if (c1_q == last_tick) begin
                        state_d = StDone;
                        c0_d    = '0;
                        c1_d    = '0;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
`ifdef ROUND_ROBIN_EN
                        prio_d  = ~owner_q;
`endif
                    end else begin
                        c0_d   = '0;
                        c1_d   = c1_q + CwOne;
                        gnt0_d = ~owner_q;
                        gnt1_d = owner_q;
                    end
                end else begin
                    c0_d   = c0_q + 3'd1;
                    gnt0_d = ~owner_q;
                    gnt1_d = owner_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                c0_d    = '0;
                c1_d    = '0;
            end
            default: begin
                state_d = StIdle;
                c0_d    = '0;
                c1_d    = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and registered-output update; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            len_q   <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
`ifdef ROUND_ROBIN_EN
            prio_q  <= prio_d;
`endif
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;
    assign c0    = c0_q;
    assign c1    = c1_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// Self-checking bench for interval_arbiter: a cycle-count model checked on every
// negedge, plus directed scenarios with literal expectations. A second, narrow
// instance (CW=4) exercises the all-ones length boundary in few cycles.
module tb_interval_arbiter;

    localparam int PSN = 8;  // PS_MAX+1 ticks of the prescaler per main tick

    logic        clk = 1'b0;
    logic        rst, req0, req1;
    logic [15:0] len0, len1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [2:0]  c0;
    logic [15:0] c1;

    logic        s_req0, s_req1;
    logic [3:0]  s_len0, s_len1;
    logic        s_gnt0, s_gnt1, s_done0, s_done1, s_busy;
    logic [2:0]  s_c0;
    logic [3:0]  s_c1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interval_arbiter #(.CW(16), .PS_MAX(7)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .req1(req1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .c0(c0), .c1(c1)
    );

    interval_arbiter #(.CW(4), .PS_MAX(7)) u_small (
        .clk(clk), .rst(rst),
        .req0(s_req0), .len0(s_len0), .req1(s_req1), .len1(s_len1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1),
        .busy(s_busy), .c0(s_c0), .c1(s_c1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an interval is just a count of elapsed cycles out of PSN*len.
    int m_phase = 0;  // 0 idle, 1 granted, 2 done pulse
    bit m_owner = 0, m_prio = 0, m_valid = 0;
    int m_total = 0, m_elapsed = 0, m_len = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_prio = 0; m_owner = 0;
        end else begin
            case (m_phase)
                0: if (req0 || req1) begin
`ifdef ROUND_ROBIN_EN
                    m_owner = (req0 && req1) ? m_prio : req1;
`else
                    m_owner = !req0;
`endif
                    m_len     = m_owner ? int'(len1) : int'(len0);
                    if (m_len == 0) m_len = 1;
                    m_total   = PSN * m_len;
                    m_elapsed = 0;
                    m_phase   = 1;
                end
                1: begin
                    if (!(m_owner ? req1 : req0)) m_phase = 0;
                    else if (m_elapsed + 1 == m_total) begin
                        m_phase = 2;
                        m_prio  = !m_owner;
                    end else m_elapsed++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_gnt0", gnt0, m_phase == 1 && !m_owner);
            chk("m_gnt1", gnt1, m_phase == 1 && m_owner);
            chk("m_done0", done0, m_phase == 2 && !m_owner);
            chk("m_done1", done1, m_phase == 2 && m_owner);
            chk("m_busy", busy, m_phase != 0);
            chk("m_c0", c0, (m_phase == 1) ? (m_elapsed % PSN) : 0);
            chk("m_c1", c1, (m_phase == 1) ? (m_elapsed / PSN) : 0);
        end
    end

    // Request one interval and measure it until its done pulse.
    task automatic run_one(input bit who, input logic [15:0] len, input bit disturb,
                           output int g_cyc, output int c1_first, output int c1_max,
                           output bit got_done);
        @(negedge clk);
        if (who) begin req1 = 1'b1; len1 = len; end
        else begin req0 = 1'b1; len0 = len; end
        g_cyc = 0; c1_first = -1; c1_max = 0; got_done = 0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            @(negedge clk);
            if (disturb && i == 3) begin len0 = 16'd1; req1 = 1'b1; end
            if (disturb && i == 8) req1 = 1'b0;
            if (who ? gnt1 : gnt0) begin
                if (c1_first < 0) c1_first = int'(c1);
                g_cyc++;
                if (int'(c1) > c1_max) c1_max = int'(c1);
            end
            if (who ? done1 : done0) got_done = 1;
        end
        if (who) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic wait_grant(output bit who, output bit ok);
        ok = 0; who = 0;
        for (int i = 0; i < 100; i++) begin
            if (gnt0 || gnt1) begin ok = 1; who = gnt1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (done0 || done1) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cf, cm, gs, cms;
        bit dn, ok, who, seen, wrap, prev_g;
        logic [3:0] prev_c;

        rst = 1'b1; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
        s_req0 = 0; s_req1 = 0; s_len0 = 0; s_len1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_c1", c1, 0);
        rst = 1'b0;

        // Length 2: 16 granted cycles, c1 0 then 1, done, then idle.
        run_one(0, 16'd2, 0, g, cf, cm, dn);
        chk("len2_gnt_cycles", g, 16);
        chk("len2_c1_first", cf, 0);
        chk("len2_c1_max", cm, 1);
        chk("len2_done", dn, 1);
        @(negedge clk);
        chk("len2_busy_after", busy, 0);

        // Len and non-owner req disturbed mid-interval: length 3 still holds.
        run_one(0, 16'd3, 1, g, cf, cm, dn);
        chk("dist_gnt_cycles", g, 24);
        chk("dist_c1_max", cm, 2);
        chk("dist_done", dn, 1);
        @(negedge clk);

        // Zero length on requester 1 runs a single main tick.
        run_one(1, 16'd0, 0, g, cf, cm, dn);
        chk("len0_gnt_cycles", g, 8);
        chk("len0_done", dn, 1);
        @(negedge clk);

        // Both requesting, length 1 each: grant order over four intervals.
        @(negedge clk);
        req0 = 1; req1 = 1; len0 = 16'd1; len1 = 16'd1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, ok);
            chk("tie_grant_seen", ok, 1);
`ifdef ROUND_ROBIN_EN
            chk("tie_order", who, k % 2);
`else
            chk("tie_order", who, 0);
`endif
            wait_done(ok);
            chk("tie_done_seen", ok, 1);
        end
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Abort requester 0 at c1=3 of length 10.
        req0 = 1; len0 = 16'd10;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt0 && c1 == 16'd3) begin ok = 1; break; end
        end
        chk("abort_reach", ok, 1);
        req0 = 0;
        @(negedge clk);
        chk("abort_gnt0", gnt0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_c0", c0, 0);
        chk("abort_c1", c1, 0);
        seen = done0;
        repeat (3) begin @(negedge clk); seen |= done0; end
        chk("abort_no_done", seen, 0);
        req0 = 1; req1 = 1; len0 = 16'd1; len1 = 16'd1;
        wait_grant(who, ok);
        chk("abort_tie_seen", ok, 1);
        chk("abort_tie_winner", who, 0);
        wait_done(ok);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Reset mid-interval at c0=5, c1=7 while requester 1 owns the counter.
        req1 = 1; len1 = 16'd20;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gnt1 && c1 == 16'd7 && c0 == 3'd5) begin ok = 1; break; end
        end
        chk("rstrun_reach", ok, 1);
        rst = 1;
        @(negedge clk);
        chk("rstrun_gnt1", gnt1, 0);
        chk("rstrun_done1", done1, 0);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_c0", c0, 0);
        chk("rstrun_c1", c1, 0);
        @(negedge clk);
        chk("rstrun_hold_busy", busy, 0);
        rst = 0; req1 = 0;
        seen = 0;
        repeat (2) begin @(negedge clk); seen |= done0 | done1; end
        chk("rstrun_no_done", seen, 0);
        req0 = 1; req1 = 1; len0 = 16'd1; len1 = 16'd1;
        wait_grant(who, ok);
        chk("rstrun_tie_seen", ok, 1);
        chk("rstrun_tie_winner", who, 0);
        wait_done(ok);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // All-ones length on the narrow instance: 15*8 cycles, c1 peaks at 14.
        s_req0 = 1; s_len0 = 4'hF;
        gs = 0; cms = 0; dn = 0; wrap = 0; prev_g = 0; prev_c = 0;
        for (int i = 0; i < 300 && !dn; i++) begin
            @(negedge clk);
            if (s_gnt0) begin
                gs++;
                if (int'(s_c1) > cms) cms = int'(s_c1);
                if (prev_g && s_c1 < prev_c) wrap = 1;
            end
            prev_g = s_gnt0; prev_c = s_c1;
            if (s_done0) dn = 1;
        end
        s_req0 = 0;
        chk("max_gnt_cycles", gs, 120);
        chk("max_c1_peak", cms, 14);
        chk("max_no_wrap", wrap, 0);
        chk("max_done", dn, 1);
        repeat (2) @(negedge clk);
        chk("max_idle_busy", s_busy, 0);
        chk("max_idle_gnt1", s_gnt1, 0);
        chk("max_idle_done1", s_done1, 0);
        chk("max_idle_c0", s_c0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
